control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have no parameters; opcode map and T-step sequences are fixed by this document.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 clr  in  1  synchronous, active-high reset.
REQ-004 ir  in  32  IR contents; opcode = ir[31:27].
REQ-005 con_ff  in  1  CONFF result, sampled in br T6.
REQ-006 ALU_Sel  out  6  ALU operation; {1'b0, opcode} when an ALU strobe is active, else 0.
REQ-007 reg_enable  out  32  load strobes: [16]HIin [17]LOin [18]Zhighin [19]Zlowin [20]PCin [21]IRin [22]MDRin [23]MARin [24]Yin; other bits 0.
REQ-008 out_sel  out  32  one-hot bus-source select to encoder: [16]HIout [17]LOout [18]Zhighout [19]Zlowout [20]PCout [22]MDRout [23]InPortout [24]Cout; other bits 0.
REQ-009 read, write, incPC, Gra, Grb, Grc, Rin, Rout, BAout, conIn  out  1 each  datapath strobes.
REQ-010 out_en  out  1  output-port load strobe.
REQ-011 run  out  1  high unless halted.
REQ-012 step  out  3  current T-step (0-7), debug.

Function
REQ-013 SHALL be a Moore FSM: all outputs decoded from registered state {RST, T0-T7, HALT} and latched ir; at most one out_sel bit high per cycle.
REQ-014 RST: all strobes 0; next T0.
REQ-015 Fetch: T0 PCout MARin incPC; T1 read MDRin; T2 MDRout IRin. Opcode is decoded from T3 on.
REQ-016 add/sub/and/or/ror/rol/shr/shra/shl (00011-01011): T3 Grb Rout Yin; T4 Grc Rout ALU Zlowin; T5 Zlowout Gra Rin; then T0.
REQ-017 addi/andi/ori (01100-01110): as REQ-016 with T4 using Cout in place of Grc Rout.
REQ-018 ldi (00001): T3 Grb BAout Yin; T4 Cout ALU_Sel=ADD(3) Zlowin; T5 Zlowout Gra Rin.
REQ-019 ld (00000): T3-T4 as ldi; T5 Zlowout MARin; T6 read MDRin; T7 MDRout Gra Rin.
REQ-020 st (00010): T3-T5 as ld; T6 Gra Rout MDRin (read=0); T7 write.
REQ-021 mul/div (01111/10000): T3 Gra Rout Yin; T4 Grb Rout ALU Zhighin Zlowin; T5 Zlowout LOin; T6 Zhighout HIin.
REQ-022 neg/not (10001/10010): T3 Grb Rout ALU Zlowin; T4 Zlowout Gra Rin.
REQ-023 br (10011): T3 Gra Rout conIn; T4 PCout Yin; T5 Cout ALU_Sel=ADD Zlowin; T6 Zlowout, PCin iff con_ff=1; T6 always returns to T0.
REQ-024 jr (10100): T3 Gra Rout PCin.
REQ-025 in (10110): T3 InPortout Gra Rin. out (10111): T3 Gra Rout out_en. mfhi/mflo (11000/11001): T3 HIout/LOout Gra Rin.
REQ-026 nop (11010) and undefined opcodes: T3 no strobes, then T0.
REQ-027 halt (11011): T3 -> HALT; HALT holds indefinitely, all strobes 0, run=0.
REQ-028 Final step of every instruction SHALL return to T0 next cycle; no write or PCin outside steps listed above.

Reset
REQ-029 clr sampled high SHALL force RST next cycle from any state, including HALT and mid-instruction; partial instruction abandoned, no write/Rin issued.
REQ-030 While clr high, state remains RST: all outputs 0, run=1, step=0.
REQ-031 First cycle after clr released is RST; T0 follows.

Verification
REQ-032 clr 2 cycles, release -> 1 RST cycle, then T0: out_sel[20], reg_enable[23], incPC =1.
REQ-033 ir=0x19890000 (add R3,R1,R2) -> T4 ALU_Sel=3, reg_enable[19]=1; T5 out_sel[19], Rin, Gra=1; T0 next.
REQ-034 st opcode -> write=1 only in T7; read=0 in T6; MDRin in T6.
REQ-035 ir=0x98000000 (br), con_ff=0 -> T6 out_sel[19]=1, reg_enable[20]=0; con_ff=1 -> reg_enable[20]=1.
REQ-036 ir=0xD8000000 (halt) -> HALT, run=0 for 20+ cycles, no strobes; clr -> RST then T0, run=1.
REQ-037 clr asserted during ld T6 -> next cycle RST, no MDRout/Rin in T7 slot.

Source files
------------

// File: rtl/control_unit_if.sv
// Control unit <-> datapath bundle: instruction/condition in, strobes out.
interface control_unit_if;
    logic [31:0] ir;
    logic        con_ff;
    logic [5:0]  ALU_Sel;
    logic [31:0] reg_enable;
    logic [31:0] out_sel;
    logic        read;
    logic        write;
    logic        incPC;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;
    logic        BAout;
    logic        conIn;
    logic        out_en;
    logic        run;
    logic [2:0]  step;

    // Control unit side
    modport master (
        input  ir, con_ff,
        output ALU_Sel, reg_enable, out_sel, read, write, incPC,
               Gra, Grb, Grc, Rin, Rout, BAout, conIn, out_en, run, step
    );

    // Datapath side
    modport slave (
        output ir, con_ff,
        input  ALU_Sel, reg_enable, out_sel, read, write, incPC,
               Gra, Grb, Grc, Rin, Rout, BAout, conIn, out_en, run, step
    );
endinterface

// File: rtl/control_unit.sv
// Moore control unit for the T-step datapath: fetch (T0-T2), opcode-specific
// execute (T3-T7), HALT. Strobes are registered: each edge computes the next
// state and loads the strobe set belonging to it.
module control_unit (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master bus
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef struct packed {
        logic [5:0]  alu_sel;
        logic [31:0] reg_enable;
        logic [31:0] out_sel;
        logic        read;
        logic        write;
        logic        incpc;
        logic        gra;
        logic        grb;
        logic        grc;
        logic        rin;
        logic        rout;
        logic        baout;
        logic        conin;
        logic        out_en;
        logic        run;
        logic [2:0]  step;
    } ctl_t;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [5:0] ALU_ADD = 6'd3;

    // reg_enable bit positions
    localparam int unsigned RE_HI  = 16;
    localparam int unsigned RE_LO  = 17;
    localparam int unsigned RE_ZH  = 18;
    localparam int unsigned RE_ZL  = 19;
    localparam int unsigned RE_PC  = 20;
    localparam int unsigned RE_IR  = 21;
    localparam int unsigned RE_MDR = 22;
    localparam int unsigned RE_MAR = 23;
    localparam int unsigned RE_Y   = 24;
    // out_sel bit positions
    localparam int unsigned OS_HI  = 16;
    localparam int unsigned OS_LO  = 17;
    localparam int unsigned OS_ZH  = 18;
    localparam int unsigned OS_ZL  = 19;
    localparam int unsigned OS_PC  = 20;
    localparam int unsigned OS_MDR = 22;
    localparam int unsigned OS_INP = 23;
    localparam int unsigned OS_C   = 24;

    state_t     state;
    state_t     nxt_c;
    logic [4:0] op_q;
    logic [4:0] op_c;
    ctl_t       ctl_q;
    logic       unused_ir;

    // Last T-step of each instruction class (halt leaves T3 for HALT instead).
    function automatic logic [2:0] last_step(input logic [4:0] op);
        logic [2:0] s;
        case (op) inside
            OP_LD, OP_ST:            s = 3'd7;
            OP_LDI, [OP_ADD:OP_ORI]: s = 3'd5;
            OP_MUL, OP_DIV, OP_BR:   s = 3'd6;
            OP_NEG, OP_NOT:          s = 3'd4;
            default:                 s = 3'd3;
        endcase
        return s;
    endfunction

    function automatic state_t next_state(input state_t st, input logic [4:0] op);
        state_t n;
        case (st)
            S_RST:   n = S_T0;
            S_T0:    n = S_T1;
            S_T1:    n = S_T2;
            S_T2:    n = S_T3;
            S_T3:    n = (op == OP_HALT) ? S_HALT :
                         (last_step(op) == 3'd3) ? S_T0 : S_T4;
            S_T4:    n = (last_step(op) == 3'd4) ? S_T0 : S_T5;
            S_T5:    n = (last_step(op) == 3'd5) ? S_T0 : S_T6;
            S_T6:    n = (last_step(op) == 3'd6) ? S_T0 : S_T7;
            S_T7:    n = S_T0;
            S_HALT:  n = S_HALT;
            default: n = S_RST;
        endcase
        return n;
    endfunction

    // Strobe set for a state; cf only matters for the br PC update in T6.
    function automatic ctl_t decode(input state_t st, input logic [4:0] op, input logic cf);
        ctl_t c;
        c     = '0;
        c.run = (st != S_HALT);
        case (st)
            S_T0: begin
                c.out_sel[OS_PC]     = 1'b1;
                c.reg_enable[RE_MAR] = 1'b1;
                c.incpc              = 1'b1;
            end
            S_T1: begin
                c.step               = 3'd1;
                c.read               = 1'b1;
                c.reg_enable[RE_MDR] = 1'b1;
            end
            S_T2: begin
                c.step              = 3'd2;
                c.out_sel[OS_MDR]   = 1'b1;
                c.reg_enable[RE_IR] = 1'b1;
            end
            S_T3: begin
                c.step = 3'd3;
                case (op) inside
                    [OP_ADD:OP_ORI]: begin c.grb = 1'b1; c.rout = 1'b1; c.reg_enable[RE_Y] = 1'b1; end
                    OP_LD, OP_LDI, OP_ST: begin c.grb = 1'b1; c.baout = 1'b1; c.reg_enable[RE_Y] = 1'b1; end
                    OP_MUL, OP_DIV: begin c.gra = 1'b1; c.rout = 1'b1; c.reg_enable[RE_Y] = 1'b1; end
                    OP_NEG, OP_NOT: begin
                        c.grb = 1'b1; c.rout = 1'b1;
                        c.alu_sel = {1'b0, op}; c.reg_enable[RE_ZL] = 1'b1;
                    end
                    OP_BR:   begin c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1; end
                    OP_JR:   begin c.gra = 1'b1; c.rout = 1'b1; c.reg_enable[RE_PC] = 1'b1; end
                    OP_IN:   begin c.out_sel[OS_INP] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    OP_OUT:  begin c.gra = 1'b1; c.rout = 1'b1; c.out_en = 1'b1; end
                    OP_MFHI: begin c.out_sel[OS_HI] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    OP_MFLO: begin c.out_sel[OS_LO] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                c.step = 3'd4;
                case (op) inside
                    [OP_ADD:OP_SHL]: begin
                        c.grc = 1'b1; c.rout = 1'b1;
                        c.alu_sel = {1'b0, op}; c.reg_enable[RE_ZL] = 1'b1;
                    end
                    [OP_ADDI:OP_ORI]: begin
                        c.out_sel[OS_C] = 1'b1;
                        c.alu_sel = {1'b0, op}; c.reg_enable[RE_ZL] = 1'b1;
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        c.out_sel[OS_C] = 1'b1;
                        c.alu_sel = ALU_ADD; c.reg_enable[RE_ZL] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        c.grb = 1'b1; c.rout = 1'b1; c.alu_sel = {1'b0, op};
                        c.reg_enable[RE_ZH] = 1'b1; c.reg_enable[RE_ZL] = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin c.out_sel[OS_ZL] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    OP_BR:   begin c.out_sel[OS_PC] = 1'b1; c.reg_enable[RE_Y] = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                c.step = 3'd5;
                case (op) inside
                    OP_LDI, [OP_ADD:OP_ORI]: begin c.out_sel[OS_ZL] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    OP_LD, OP_ST:   begin c.out_sel[OS_ZL] = 1'b1; c.reg_enable[RE_MAR] = 1'b1; end
                    OP_MUL, OP_DIV: begin c.out_sel[OS_ZL] = 1'b1; c.reg_enable[RE_LO] = 1'b1; end
                    OP_BR: begin
                        c.out_sel[OS_C] = 1'b1;
                        c.alu_sel = ALU_ADD; c.reg_enable[RE_ZL] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                c.step = 3'd6;
                case (op)
                    OP_LD:  begin c.read = 1'b1; c.reg_enable[RE_MDR] = 1'b1; end
                    OP_ST:  begin c.gra = 1'b1; c.rout = 1'b1; c.reg_enable[RE_MDR] = 1'b1; end
                    OP_MUL, OP_DIV: begin c.out_sel[OS_ZH] = 1'b1; c.reg_enable[RE_HI] = 1'b1; end
                    OP_BR:  begin c.out_sel[OS_ZL] = 1'b1; c.reg_enable[RE_PC] = cf; end
                    default: ;
                endcase
            end
            S_T7: begin
                c.step = 3'd7;
                case (op)
                    OP_LD:   begin c.out_sel[OS_MDR] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    OP_ST:   c.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return c;
    endfunction

    // Opcode is captured on the T2->T3 edge so the T3 strobes can be registered.
    assign op_c      = (state == S_T2) ? bus.ir[31:27] : op_q;
    assign nxt_c     = next_state(state, op_c);
    assign unused_ir = ^bus.ir[26:0];

    // State, opcode latch and registered strobes; clr wins from any state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_RST;
            op_q  <= '0;
            ctl_q <= decode(S_RST, 5'd0, 1'b0);
        end else begin
            state <= nxt_c;
            op_q  <= op_c;
            ctl_q <= decode(nxt_c, op_c, bus.con_ff);
        end
    end

    assign bus.ALU_Sel    = ctl_q.alu_sel;
    assign bus.reg_enable = ctl_q.reg_enable;
    assign bus.out_sel    = ctl_q.out_sel;
    assign bus.read       = ctl_q.read;
    assign bus.write      = ctl_q.write;
    assign bus.incPC      = ctl_q.incpc;
    assign bus.Gra        = ctl_q.gra;
    assign bus.Grb        = ctl_q.grb;
    assign bus.Grc        = ctl_q.grc;
    assign bus.Rin        = ctl_q.rin;
    assign bus.Rout       = ctl_q.rout;
    assign bus.BAout      = ctl_q.baout;
    assign bus.conIn      = ctl_q.conin;
    assign bus.out_en     = ctl_q.out_en;
    assign bus.run        = ctl_q.run;
    assign bus.step       = ctl_q.step;
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction strobe sequences built from the
// instruction descriptions, table of fixed instructions, reset/halt corner
// sequences and randomized instruction streams with random mid-instruction clr.
module tb_control_unit;
    typedef struct packed {
        logic [5:0]  alu;
        logic [31:0] re;
        logic [31:0] os;
        logic        rd, wr, inc, gra, grb, grc, rin, rout, ba, ci, oe, run;
        logic [2:0]  step;
    } exp_t;

    typedef struct {
        logic [31:0] ir;
        logic        cf;
        int          ncyc;
        string       name;
    } vec_t;

    logic clk;
    logic clr;
    int   total;
    int   bad;
    exp_t exp_q[$];

    control_unit_if bus ();

    control_unit u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t blank(input int s);
        exp_t e;
        e      = '0;
        e.run  = 1'b1;
        e.step = 3'(s);
        return e;
    endfunction

    function automatic logic [10:0] strb(input exp_t e);
        return {e.rd, e.wr, e.inc, e.gra, e.grb, e.grc, e.rin, e.rout, e.ba, e.ci, e.oe};
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.alu = bus.ALU_Sel; a.re = bus.reg_enable; a.os = bus.out_sel;
        a.rd = bus.read; a.wr = bus.write; a.inc = bus.incPC;
        a.gra = bus.Gra; a.grb = bus.Grb; a.grc = bus.Grc;
        a.rin = bus.Rin; a.rout = bus.Rout; a.ba = bus.BAout; a.ci = bus.conIn;
        a.oe = bus.out_en; a.run = bus.run; a.step = bus.step;
        return a;
    endfunction

    // Expected cycle-by-cycle strobes for one instruction, fetch included.
    function automatic void build(input logic [4:0] op, input logic cf);
        exp_t e;
        exp_q.delete();
        e = blank(0); e.os[20] = 1'b1; e.re[23] = 1'b1; e.inc = 1'b1; exp_q.push_back(e);
        e = blank(1); e.rd = 1'b1; e.re[22] = 1'b1; exp_q.push_back(e);
        e = blank(2); e.os[22] = 1'b1; e.re[21] = 1'b1; exp_q.push_back(e);
        if (op >= 5'd3 && op <= 5'd14) begin
            e = blank(3); e.grb = 1'b1; e.rout = 1'b1; e.re[24] = 1'b1; exp_q.push_back(e);
            e = blank(4);
            if (op <= 5'd11) begin e.grc = 1'b1; e.rout = 1'b1; end
            else e.os[24] = 1'b1;
            e.alu = {1'b0, op}; e.re[19] = 1'b1; exp_q.push_back(e);
            e = blank(5); e.os[19] = 1'b1; e.gra = 1'b1; e.rin = 1'b1; exp_q.push_back(e);
        end else if (op <= 5'd2) begin
            e = blank(3); e.grb = 1'b1; e.ba = 1'b1; e.re[24] = 1'b1; exp_q.push_back(e);
            e = blank(4); e.os[24] = 1'b1; e.alu = 6'd3; e.re[19] = 1'b1; exp_q.push_back(e);
            e = blank(5); e.os[19] = 1'b1;
            if (op == 5'd1) begin
                e.gra = 1'b1; e.rin = 1'b1; exp_q.push_back(e);
            end else begin
                e.re[23] = 1'b1; exp_q.push_back(e);
                e = blank(6); e.re[22] = 1'b1;
                if (op == 5'd0) e.rd = 1'b1;
                else begin e.gra = 1'b1; e.rout = 1'b1; end
                exp_q.push_back(e);
                e = blank(7);
                if (op == 5'd0) begin e.os[22] = 1'b1; e.gra = 1'b1; e.rin = 1'b1; end
                else e.wr = 1'b1;
                exp_q.push_back(e);
            end
        end else if (op == 5'd15 || op == 5'd16) begin
            e = blank(3); e.gra = 1'b1; e.rout = 1'b1; e.re[24] = 1'b1; exp_q.push_back(e);
            e = blank(4); e.grb = 1'b1; e.rout = 1'b1; e.alu = {1'b0, op};
            e.re[18] = 1'b1; e.re[19] = 1'b1; exp_q.push_back(e);
            e = blank(5); e.os[19] = 1'b1; e.re[17] = 1'b1; exp_q.push_back(e);
            e = blank(6); e.os[18] = 1'b1; e.re[16] = 1'b1; exp_q.push_back(e);
        end else if (op == 5'd17 || op == 5'd18) begin
            e = blank(3); e.grb = 1'b1; e.rout = 1'b1; e.alu = {1'b0, op}; e.re[19] = 1'b1;
            exp_q.push_back(e);
            e = blank(4); e.os[19] = 1'b1; e.gra = 1'b1; e.rin = 1'b1; exp_q.push_back(e);
        end else if (op == 5'd19) begin
            e = blank(3); e.gra = 1'b1; e.rout = 1'b1; e.ci = 1'b1; exp_q.push_back(e);
            e = blank(4); e.os[20] = 1'b1; e.re[24] = 1'b1; exp_q.push_back(e);
            e = blank(5); e.os[24] = 1'b1; e.alu = 6'd3; e.re[19] = 1'b1; exp_q.push_back(e);
            e = blank(6); e.os[19] = 1'b1; e.re[20] = cf; exp_q.push_back(e);
        end else begin
            e = blank(3);
            case (op)
                5'd20: begin e.gra = 1'b1; e.rout = 1'b1; e.re[20] = 1'b1; end
                5'd22: begin e.os[23] = 1'b1; e.gra = 1'b1; e.rin = 1'b1; end
                5'd23: begin e.gra = 1'b1; e.rout = 1'b1; e.oe = 1'b1; end
                5'd24: begin e.os[16] = 1'b1; e.gra = 1'b1; e.rin = 1'b1; end
                5'd25: begin e.os[17] = 1'b1; e.gra = 1'b1; e.rin = 1'b1; end
                default: ;
            endcase
            exp_q.push_back(e);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input exp_t e, input string name);
        exp_t a;
        a = sample();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got step=%0d run=%b alu=%h re=%h os=%h s=%b, want step=%0d run=%b alu=%h re=%h os=%h s=%b",
                     name, a.step, a.run, a.alu, a.re, a.os, strb(a),
                     e.step, e.run, e.alu, e.re, e.os, strb(e));
        end
    endtask

    // Called in T0; leaves the DUT in T0 of the following instruction.
    task automatic run_instr(input logic [31:0] irv, input logic cf, input int ncyc,
                             input int abort_at, input string name);
        int n;
        bus.ir     = irv;
        bus.con_ff = cf;
        build(irv[31:27], cf);
        n = (ncyc > 0) ? ncyc : exp_q.size();
        for (int c = 0; c < n; c++) begin
            if (c < exp_q.size()) check(exp_q[c], name);
            else check(blank(0), {name, "_len"});
            if (c == abort_at) begin
                clr = 1'b1;
                tick();
                check(blank(0), {name, "_clr"});
                clr = 1'b0;
                tick();
                check(exp_q[0], {name, "_restart"});
                return;
            end
            tick();
        end
        check(exp_q[0], {name, "_ret"});
    endtask

    vec_t vecs[$];

    initial begin
        exp_t h;
        total      = 0;
        bad        = 0;
        clr        = 1'b1;
        bus.ir     = 32'h0;
        bus.con_ff = 1'b0;

        vecs.push_back('{32'h19890000, 1'b0, 6, "add"});
        vecs.push_back('{32'h20000000, 1'b0, 6, "sub"});
        vecs.push_back('{32'h38000000, 1'b0, 6, "ror"});
        vecs.push_back('{32'h58000000, 1'b0, 6, "shl"});
        vecs.push_back('{32'h61000005, 1'b0, 6, "addi"});
        vecs.push_back('{32'h70000000, 1'b0, 6, "ori"});
        vecs.push_back('{32'h08000000, 1'b0, 6, "ldi"});
        vecs.push_back('{32'h00000000, 1'b0, 8, "ld"});
        vecs.push_back('{32'h10000000, 1'b0, 8, "st"});
        vecs.push_back('{32'h78000000, 1'b0, 7, "mul"});
        vecs.push_back('{32'h80000000, 1'b0, 7, "div"});
        vecs.push_back('{32'h88000000, 1'b0, 5, "neg"});
        vecs.push_back('{32'h90000000, 1'b0, 5, "not"});
        vecs.push_back('{32'h98000000, 1'b0, 7, "br_cf0"});
        vecs.push_back('{32'h98000000, 1'b1, 7, "br_cf1"});
        vecs.push_back('{32'hA0000000, 1'b0, 4, "jr"});
        vecs.push_back('{32'hA8000000, 1'b0, 4, "undef21"});
        vecs.push_back('{32'hB0000000, 1'b0, 4, "in"});
        vecs.push_back('{32'hB8000000, 1'b0, 4, "out"});
        vecs.push_back('{32'hC0000000, 1'b0, 4, "mfhi"});
        vecs.push_back('{32'hC8000000, 1'b0, 4, "mflo"});
        vecs.push_back('{32'hD0000000, 1'b0, 4, "nop"});
        vecs.push_back('{32'hF8000000, 1'b0, 4, "undef31"});

        // clr held two cycles, then one RST cycle, then fetch
        @(negedge clk);
        check(blank(0), "rst_hold0");
        tick();
        check(blank(0), "rst_hold1");
        clr = 1'b0;
        check(blank(0), "rst_release");
        tick();

        foreach (vecs[i]) run_instr(vecs[i].ir, vecs[i].cf, vecs[i].ncyc, -1, vecs[i].name);

        // clr in ld T6: next cycle RST, T7 strobes never appear
        run_instr(32'h00000000, 1'b0, 0, 6, "ld_abort");

        // halt holds with no strobes until clr
        bus.ir = 32'hD8000000;
        build(5'd27, 1'b0);
        foreach (exp_q[i]) begin
            check(exp_q[i], "halt_entry");
            tick();
        end
        h = '0;
        for (int k = 0; k < 25; k++) begin
            check(h, "halt_hold");
            tick();
        end
        clr = 1'b1;
        tick();
        check(blank(0), "halt_clr");
        clr = 1'b0;
        tick();
        check(exp_q[0], "halt_t0");

        // random instruction stream with occasional mid-instruction clr
        for (int k = 0; k < 150; k++) begin
            logic [31:0] irv;
            logic [4:0]  op;
            int          ab;
            op  = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            irv = {op, 27'($urandom)};
            build(op, 1'b0);
            ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
            run_instr(irv, 1'($urandom_range(0, 1)), 0, ab, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
